// File: rtl/op_sweep_if.sv
// Signal bundle between the sweep controller and the unit/host it serves.
// The sig_out member exists only when OP_SWEEP_SIG_EN is defined.
interface op_sweep_if #(
  parameter int WIDTH = 5
);
  logic             start;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic [1:0]       s_out;
  logic [WIDTH-1:0] a_out;
  logic [WIDTH-1:0] b_out;
  logic [WIDTH-1:0] y_in;
  logic             busy;
  logic             done;
  logic [1:0]       res_sel;
  logic [WIDTH-1:0] res_out;
`ifdef OP_SWEEP_SIG_EN
  logic [WIDTH-1:0] sig_out;
`endif

  // master: the sweep controller
  modport master (
    input  start, a_in, b_in, y_in, res_sel,
    output s_out, a_out, b_out, busy, done, res_out
`ifdef OP_SWEEP_SIG_EN
    , output sig_out
`endif
  );

  // slave: the function unit and readback host
  modport slave (
    output start, a_in, b_in, y_in, res_sel,
    input  s_out, a_out, b_out, busy, done, res_out
`ifdef OP_SWEEP_SIG_EN
    , input sig_out
`endif
  );
endinterface

// File: rtl/op_sweep_ctrl.sv
// Self-test sweep controller: latches A/B, walks select 00..11 holding each HOLD cycles,
// captures Y at the end of each hold. Optional rotate-XOR signature under OP_SWEEP_SIG_EN.
module op_sweep_ctrl #(
  parameter int WIDTH = 5,
  parameter int HOLD  = 20
) (
  input  logic         clk,
  input  logic         rst,
  op_sweep_if.master   bus
);

  typedef enum logic [1:0] {IDLE, DRIVE, DONE} state_t;

  localparam logic [7:0] HOLD_LAST = 8'(HOLD - 1);

  state_t           state;
  logic [7:0]       cnt;
  logic [1:0]       s_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] res_q [4];
`ifdef OP_SWEEP_SIG_EN
  logic [WIDTH-1:0] sig_q;

  function automatic logic [WIDTH-1:0] sig_step(input logic [WIDTH-1:0] sig,
                                                input logic [WIDTH-1:0] y);
    return {sig[WIDTH-2:0], sig[WIDTH-1]} ^ y;
  endfunction
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      s_q    <= '0;
      a_q    <= '0;
      b_q    <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      for (int i = 0; i < 4; i++) res_q[i] <= '0;
`ifdef OP_SWEEP_SIG_EN
      sig_q  <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            a_q    <= bus.a_in;
            b_q    <= bus.b_in;
            s_q    <= 2'b00;
            cnt    <= '0;
            busy_q <= 1'b1;
            state  <= DRIVE;
`ifdef OP_SWEEP_SIG_EN
            sig_q  <= '0;
`endif
          end
        end
        DRIVE: begin
          // Y is sampled in the final cycle of the hold, giving the unit HOLD-1 cycles to settle.
          if (cnt == HOLD_LAST) begin
            res_q[s_q] <= bus.y_in;
            cnt        <= '0;
`ifdef OP_SWEEP_SIG_EN
            sig_q      <= sig_step(sig_q, bus.y_in);
`endif
            if (s_q == 2'b11) begin
              busy_q <= 1'b0;
              done_q <= 1'b1;
              state  <= DONE;
            end else begin
              s_q <= s_q + 2'd1;
            end
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        DONE: begin
          // start is deliberately not sampled here, so back-to-back sweeps see one IDLE cycle.
          done_q <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.s_out   = s_q;
  assign bus.a_out   = a_q;
  assign bus.b_out   = b_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.res_out = res_q[bus.res_sel];
`ifdef OP_SWEEP_SIG_EN
  assign bus.sig_out = sig_q;
`endif

endmodule

// File: tb/tb_op_sweep_ctrl.sv
// Bench for op_sweep_ctrl with HOLD=4 and a modelled unit y = a + b + s.
// Checks the per-cycle timeline, readback, reset and back-to-back behaviour against a reference model.
module tb_op_sweep_ctrl;
  localparam int W = 5;
  localparam int H = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  op_sweep_if #(.WIDTH(W)) bus ();
  op_sweep_ctrl #(.WIDTH(W), .HOLD(H)) dut (.clk(clk), .rst(rst), .bus(bus));

  // Function unit model driven by the controller's outputs
  assign bus.y_in = bus.a_out + bus.b_out + {3'b000, bus.s_out};

  int n_chk  = 0;
  int n_pass = 0;
  logic [W-1:0] exp_res [4];
  logic [W-1:0] exp_sig;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  function automatic logic [W-1:0] unit_y(input logic [W-1:0] a, input logic [W-1:0] b, input int k);
    return W'(int'(a) + int'(b) + k);
  endfunction

  function automatic logic [W-1:0] rotl_xor(input logic [W-1:0] s, input logic [W-1:0] y);
    return W'(((int'(s) << 1) | (int'(s) >> (W - 1))) ^ int'(y));
  endfunction

  task automatic check_res_all(input string tag);
    for (int j = 0; j < 4; j++) begin
      bus.res_sel = 2'(j);
      #1;
      chk(tag, 32'(bus.res_out), 32'(exp_res[j]));
    end
  endtask

  // One sweep checked cycle by cycle; disturb perturbs operands and pulses start mid-sweep.
  task automatic sweep(input logic [W-1:0] a, input logic [W-1:0] b, input bit disturb);
    logic [1:0] sel;
    @(negedge clk);
    bus.a_in  = a;
    bus.b_in  = b;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    exp_sig   = '0;
    for (int k = 0; k <= 4 * H + 1; k++) begin
      if (k > 0) @(negedge clk);
      if (k > 0 && k % H == 0 && k <= 4 * H) begin
        exp_res[k / H - 1] = unit_y(a, b, k / H - 1);
        exp_sig = rotl_xor(exp_sig, exp_res[k / H - 1]);
      end
      chk("busy", 32'(bus.busy), 32'(k < 4 * H));
      chk("done", 32'(bus.done), 32'(k == 4 * H));
      chk("s_out", 32'(bus.s_out), (k < 4 * H) ? 32'(k / H) : 32'd3);
      chk("a_out", 32'(bus.a_out), 32'(a));
      chk("b_out", 32'(bus.b_out), 32'(b));
`ifdef OP_SWEEP_SIG_EN
      chk("sig_out", 32'(bus.sig_out), 32'(exp_sig));
`endif
      sel = 2'($urandom_range(0, 3));
      bus.res_sel = sel;
      #1;
      chk("res_live", 32'(bus.res_out), 32'(exp_res[sel]));
      if (disturb && k == 5) begin
        bus.a_in = '1;
        bus.b_in = W'($urandom);
      end
      if (disturb) bus.start = (k == 7 || k == 2 * H + 1);
    end
    bus.start = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("idle_busy", 32'(bus.busy), 32'd0);
      chk("idle_done", 32'(bus.done), 32'd0);
    end
    check_res_all("res_final");
  endtask

  initial begin
    int pulse_at [3];
    int np;
    rst         = 1'b1;
    bus.start   = 1'b0;
    bus.a_in    = '0;
    bus.b_in    = '0;
    bus.res_sel = 2'd0;
    for (int j = 0; j < 4; j++) exp_res[j] = '0;
    exp_sig = '0;
    #3;
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_s", 32'(bus.s_out), 32'd0);
    chk("rst_a", 32'(bus.a_out), 32'd0);
    chk("rst_b", 32'(bus.b_out), 32'd0);
    check_res_all("rst_res");
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("idle_noop", 32'(bus.busy), 32'd0);

    // Reference vector, then operand-stability run, then random operands
    sweep(5'b00101, 5'b01010, 1'b0);
`ifdef OP_SWEEP_SIG_EN
    chk("sig_final", 32'(bus.sig_out), 32'b01000);
`endif
    sweep(5'b00101, 5'b01010, 1'b1);
    repeat (4) sweep(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)));

    // Mid-sweep asynchronous reset after the second capture
    @(negedge clk);
    bus.a_in  = 5'b00101;
    bus.b_in  = 5'b01010;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (2 * H) @(negedge clk);
    bus.res_sel = 2'd1;
    #1;
    chk("pre_rst_res1", 32'(bus.res_out), 32'(unit_y(5'b00101, 5'b01010, 1)));
    #1;
    rst = 1'b1;
    #1;
    chk("arst_busy", 32'(bus.busy), 32'd0);
    chk("arst_s", 32'(bus.s_out), 32'd0);
    chk("arst_a", 32'(bus.a_out), 32'd0);
    chk("arst_b", 32'(bus.b_out), 32'd0);
`ifdef OP_SWEEP_SIG_EN
    chk("arst_sig", 32'(bus.sig_out), 32'd0);
`endif
    for (int j = 0; j < 4; j++) exp_res[j] = '0;
    check_res_all("arst_res");
    @(negedge clk);
    rst = 1'b0;
    np = 0;
    repeat (4 * H + 4) begin
      @(negedge clk);
      if (bus.done) np++;
    end
    chk("arst_no_done", 32'(np), 32'd0);
    sweep(5'b00101, 5'b01010, 1'b0);

    // Back-to-back with start held high: expected done at 17, 35, 53 cycles after raising start
    @(negedge clk);
    bus.a_in  = 5'b00101;
    bus.b_in  = 5'b01010;
    bus.start = 1'b1;
    np = 0;
    for (int i = 1; i <= 80 && np < 3; i++) begin
      @(negedge clk);
      if (bus.done) begin
        pulse_at[np] = i;
        np++;
        if (np == 3) bus.start = 1'b0;
      end
    end
    bus.start = 1'b0;
    chk("b2b_npulse", 32'(np), 32'd3);
    if (np == 3) begin
      chk("b2b_first", 32'(pulse_at[0]), 32'(4 * H + 1));
      chk("b2b_period1", 32'(pulse_at[1] - pulse_at[0]), 32'(4 * H + 2));
      chk("b2b_period2", 32'(pulse_at[2] - pulse_at[1]), 32'(4 * H + 2));
    end
    repeat (3) begin
      @(negedge clk);
      chk("b2b_stop", 32'(bus.busy), 32'd0);
    end
    for (int j = 0; j < 4; j++) exp_res[j] = unit_y(5'b00101, 5'b01010, j);
    check_res_all("b2b_res");
`ifdef OP_SWEEP_SIG_EN
    chk("b2b_sig", 32'(bus.sig_out), 32'b01000);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/op_sweep_ctrl.md
Name: op_sweep_ctrl

Overview:
Synthesizable sweep controller for the 2-bit-select, 5-bit-operand function unit. On start it latches one A/B operand pair, steps the select through 00, 01, 10, 11, and holds each code for a fixed number of cycles. It samples the unit's Y output at the end of each hold and keeps the four results for readback. It is the on-chip counterpart to the bench stimulus for that unit, used for built-in self-test.

Parameters:
WIDTH, 5, operand and result width
HOLD, 20, clock cycles each select code is held (legal range 2..255)

Ports:
clk  in  1  system clock, rising-edge
rst  in  1  asynchronous active-high reset
start  in  1  sweep request; sampled only in IDLE
a_in  in  WIDTH  operand A; latched on accepted start
b_in  in  WIDTH  operand B; latched on accepted start
s_out  out  2  select code to the function unit
a_out  out  WIDTH  latched operand A to the function unit
b_out  out  WIDTH  latched operand B to the function unit
y_in  in  WIDTH  function unit result
busy  out  1  high while sweeping
done  out  1  one-cycle pulse when the sweep completes
res_sel  in  2  result readback index
res_out  out  WIDTH  combinational read of res[res_sel]

Interface (already decided):
- One clock, clk.
- Reset rst is asynchronous and active-high.

Behaviour:
- Reset (asynchronous, any state):
  - state = IDLE.
  - s_out, a_out, b_out, busy, done, hold counter and res[0..3] all = 0.
  - A reset in the middle of a sweep abandons it; no done pulse is produced.
- States:
  - IDLE, DRIVE, DONE.
- IDLE:
  - start=1 at an edge causes, at that edge: a_out←a_in, b_out←b_in, s_out←00, cnt←0, state←DRIVE.
  - start=0: stay in IDLE; all outputs hold.
- DRIVE:
  - busy=1.
  - Each edge: cnt←cnt+1 until cnt==HOLD-1.
  - At the edge where cnt==HOLD-1: res[s_out]←y_in, cnt←0.
  - If s_out==11 at that edge, state←DONE; otherwise s_out←s_out+1.
  - y_in is sampled in the last cycle of each hold, so the function unit gets HOLD-1 cycles to settle.
- DONE:
  - busy=0, done=1 for exactly one cycle, then state←IDLE.
- Sweep latency:
  - 4*HOLD edges in DRIVE.
  - done is high in the cycle after edge start+4*HOLD.
- Outputs after a sweep:
  - s_out holds at 11; a_out and b_out hold their latched values until the next accepted start.
- start handling:
  - start is ignored in DRIVE and DONE; it is not queued.
  - Holding start high continuously restarts a sweep in the first IDLE cycle after DONE.
- a_in and b_in changes during a sweep have no effect.
- res_out is a pure mux of the result registers. It is valid at any time, including during a sweep; entries not yet captured keep their previous values.
- Results are not cleared on start; each capture overwrites its own entry.
- No arithmetic is performed on operands. cnt is 8 bits wide and wraps only through the explicit clear.

Optional Feature:
Macro: OP_SWEEP_SIG_EN
- Defined:
  - Adds output port sig_out (WIDTH bits), reset to 0 and cleared to 0 on an accepted start.
  - At each capture edge: sig_out←{sig_out[WIDTH-2:0], sig_out[WIDTH-1]} ^ y_in (rotate left by one, then XOR).
  - sig_out holds after DONE.
- Undefined:
  - The port and its register are absent.
  - All other behaviour is identical.

Test Plan:
All scenarios use HOLD=4 and a bench model y_in = a_out + b_out + s_out, with a_in=00101 and b_in=01010.
- Basic sweep: pulse start for 1 cycle → s_out steps through 00, 01, 10, 11, each held 4 cycles; busy is high for 16 cycles; done pulses once at the cycle after edge start+16; res[0..3] read back as 01111, 10000, 10001, 10010.
- Signature (OP_SWEEP_SIG_EN defined): same stimulus → sig_out = 01111, 01110, 01101, 01000 after successive captures; final value 01000.
- Operand stability: change a_in to 11111 during DRIVE → a_out stays 00101 and results are unchanged; start pulsed during DRIVE → no restart and a single done pulse.
- Mid-sweep reset: assert rst after the second capture → all outputs and res[0..3] read 0 immediately (asynchronous); no done pulse; a fresh start then completes normally.
- Back-to-back: hold start high → second sweep begins the cycle after DONE; done pulses exactly every 18 cycles; the results match scenario 1.
